// File: rtl/piano_pkg.sv
// Shared constants and types for the piano key scanner.
// The FSM encoding and the default key count live here.
package piano_pkg;

    localparam int unsigned NUM_KEYS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        ADVANCE
    } scan_state_t;

    // Index of the last key in a pass.
    function automatic int unsigned last_key(input int unsigned num_keys);
        return num_keys - 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: flips its state after DEBOUNCE_N consecutive differing samples
// and emits a registered one-cycle rise/fall pulse when it does.
module key_debounce #(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sample,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            if (sample == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_N - 1)) begin
                // This is the DEBOUNCE_Nth differing sample: flip and restart.
                cnt_d   = '0;
                state_d = ~state_q;
                rise_d  = ~state_q;
                fall_d  = state_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state = state_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/key_scanner.sv
// Scan initiator for the piano key mux tree: walks sel_out over all keys, samples
// the mux output after a settle delay and debounces each key into a stable vector.
module key_scanner #(
    parameter int unsigned NUM_KEYS   = piano_pkg::NUM_KEYS,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned DEBOUNCE_N = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_en,
    output logic [SEL_W-1:0]    sel_out,
    input  logic                mux_in,
    output logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] press_evt,
    output logic [NUM_KEYS-1:0] release_evt,
    output logic                scan_done
);

    import piano_pkg::*;

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(last_key(NUM_KEYS));

    scan_state_t      state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                sel_d    = '0;
                settle_d = '0;
                if (scan_en) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            SAMPLE: begin
                state_d = ADVANCE;
                // Registered so the pulse lands in the ADVANCE cycle of the last key.
                done_d  = (sel_q == LAST_SEL);
            end
            ADVANCE: begin
                if (sel_q == LAST_SEL) begin
                    sel_d   = '0;
                    state_d = scan_en ? SETTLE : IDLE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            settle_q <= '0;
            sel_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
        end
    end

    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_rise;
    logic [NUM_KEYS-1:0] key_fall;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : gen_keys
        logic key_en;
        assign key_en = (state_q == SAMPLE) && (sel_q == SEL_W'(k));

        key_debounce #(
            .DEBOUNCE_N(DEBOUNCE_N)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .en    (key_en),
            .sample(mux_in),
            .state (key_state[k]),
            .rise  (key_rise[k]),
            .fall  (key_fall[k])
        );
    end

    assign sel_out     = sel_q;
    assign scan_done   = done_q;
    assign keys        = key_state;
    assign press_evt   = key_rise;
    assign release_evt = key_fall;

endmodule
